// File: rtl/lcd_char_driver_pkg.sv
// Shared LCD command codes, default 50 MHz timings and FSM types
// for the HD44780 character driver.
package lcd_char_driver_pkg;

    localparam int CNT_W = 20;

    localparam logic [7:0] FUNC_SET_4B = 8'h28;
    localparam logic [7:0] ENTRY_INC   = 8'h06;
    localparam logic [7:0] DISP_ON     = 8'h0C;
    localparam logic [7:0] CLEAR       = 8'h01;
    localparam logic [7:0] SET_DDRAM   = 8'h80;

    localparam int unsigned DEF_T_POWERUP = 750000;
    localparam int unsigned DEF_T_INIT1   = 205000;
    localparam int unsigned DEF_T_INIT2   = 5000;
    localparam int unsigned DEF_T_CMD     = 2000;
    localparam int unsigned DEF_T_CLEAR   = 82000;
    localparam int unsigned DEF_T_SETUP   = 2;
    localparam int unsigned DEF_T_EPULSE  = 12;
    localparam int unsigned DEF_T_HOLD    = 1;
    localparam int unsigned DEF_T_NIBGAP  = 50;

    typedef enum logic [3:0] {
        PWR_WAIT,
        INIT_A,
        INIT_B,
        INIT_C,
        INIT_D,
        CFG,
        IDLE,
        SET_ADDR,
        WR_CHAR
    } state_t;

    typedef enum logic [1:0] {
        S_START,
        S_WAIT_NIB,
        S_GAP,
        S_DELAY
    } step_t;

    typedef enum logic [1:0] {
        N_IDLE,
        N_SETUP,
        N_PULSE,
        N_HOLD
    } nstate_t;

    // Delay counters count down to zero, so a wait of t cycles loads t-1.
    function automatic logic [CNT_W-1:0] ld(input int unsigned t);
        return CNT_W'(t - 1);
    endfunction

    function automatic logic [7:0] cfg_byte(input logic [1:0] i);
        logic [7:0] b;
        b = FUNC_SET_4B;
        unique case (i)
            2'd0: b = FUNC_SET_4B;
            2'd1: b = ENTRY_INC;
            2'd2: b = DISP_ON;
            2'd3: b = CLEAR;
            default: b = FUNC_SET_4B;
        endcase
        return b;
    endfunction

endpackage

// File: rtl/lcd_char_driver_nibble_tx.sv
// Single nibble strobe: setup, enable pulse, hold,
// then a one-cycle done.
module lcd_nibble_tx
    import lcd_char_driver_pkg::*;
#(
    parameter int unsigned T_SETUP  = DEF_T_SETUP,
    parameter int unsigned T_EPULSE = DEF_T_EPULSE,
    parameter int unsigned T_HOLD   = DEF_T_HOLD
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [3:0] nib,
    input  logic       rs,
    output logic       lcd_e,
    output logic [3:0] lcd_d,
    output logic       lcd_rs,
    output logic       done
);

    nstate_t          st;
    logic [CNT_W-1:0] cnt;

    // lcd_d/lcd_rs only change on start, so they stay put through hold.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            st     <= N_IDLE;
            cnt    <= '0;
            lcd_e  <= 1'b0;
            lcd_d  <= 4'h0;
            lcd_rs <= 1'b0;
            done   <= 1'b0;
        end else begin
            done <= 1'b0;
            unique case (st)
                N_IDLE: begin
                    if (start) begin
                        lcd_d  <= nib;
                        lcd_rs <= rs;
                        cnt    <= ld(T_SETUP);
                        st     <= N_SETUP;
                    end
                end
                N_SETUP: begin
                    if (cnt == '0) begin
                        lcd_e <= 1'b1;
                        cnt   <= ld(T_EPULSE);
                        st    <= N_PULSE;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                N_PULSE: begin
                    if (cnt == '0) begin
                        lcd_e <= 1'b0;
                        cnt   <= ld(T_HOLD);
                        st    <= N_HOLD;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                N_HOLD: begin
                    if (cnt == '0) begin
                        done <= 1'b1;
                        st   <= N_IDLE;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                default: st <= N_IDLE;
            endcase
        end
    end

endmodule

// File: rtl/lcd_char_driver.sv
// HD44780 4-bit driver: power-on init, then rewrites one DDRAM
// cell whenever the input character changes.
module lcd_char_driver
    import lcd_char_driver_pkg::*;
#(
    parameter logic [6:0]  POS       = 7'h00,
    parameter int unsigned T_POWERUP = DEF_T_POWERUP,
    parameter int unsigned T_INIT1   = DEF_T_INIT1,
    parameter int unsigned T_INIT2   = DEF_T_INIT2,
    parameter int unsigned T_CMD     = DEF_T_CMD,
    parameter int unsigned T_CLEAR   = DEF_T_CLEAR,
    parameter int unsigned T_SETUP   = DEF_T_SETUP,
    parameter int unsigned T_EPULSE  = DEF_T_EPULSE,
    parameter int unsigned T_HOLD    = DEF_T_HOLD,
    parameter int unsigned T_NIBGAP  = DEF_T_NIBGAP
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] data,
    output logic       ready,
    output logic       lcd_e,
    output logic       lcd_rs,
    output logic       lcd_rw,
    output logic [3:0] lcd_d,
    output logic       sf_ce0
);

    state_t           state;
    state_t           next_state;
    step_t            step;
    logic             lo;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] wait_ld;
    logic [1:0]       cfg_idx;
    logic [7:0]       shadow;
    logic [7:0]       last;
    logic             valid_last;
    logic             nib_start;
    logic [3:0]       nib_val;
    logic             nib_rs;
    logic             nib_done;
    logic [7:0]       cur_byte;
    logic             cur_rs;
    logic             nib_only;
    logic [3:0]       nib_code;

    assign lcd_rw = 1'b0;
    assign sf_ce0 = 1'b1;

    lcd_nibble_tx #(
        .T_SETUP (T_SETUP),
        .T_EPULSE(T_EPULSE),
        .T_HOLD  (T_HOLD)
    ) u_tx (
        .clk   (clk),
        .rst   (rst),
        .start (nib_start),
        .nib   (nib_val),
        .rs    (nib_rs),
        .lcd_e (lcd_e),
        .lcd_d (lcd_d),
        .lcd_rs(lcd_rs),
        .done  (nib_done)
    );

    always_comb begin
        cur_byte   = 8'h00;
        cur_rs     = 1'b0;
        nib_only   = 1'b0;
        nib_code   = 4'h3;
        wait_ld    = ld(T_CMD);
        next_state = state;
        unique case (state)
            PWR_WAIT: begin
                wait_ld    = ld(T_POWERUP);
                next_state = INIT_A;
            end
            INIT_A: begin
                nib_only   = 1'b1;
                wait_ld    = ld(T_INIT1);
                next_state = INIT_B;
            end
            INIT_B: begin
                nib_only   = 1'b1;
                wait_ld    = ld(T_INIT2);
                next_state = INIT_C;
            end
            INIT_C: begin
                nib_only   = 1'b1;
                next_state = INIT_D;
            end
            INIT_D: begin
                nib_only   = 1'b1;
                nib_code   = 4'h2;
                next_state = CFG;
            end
            CFG: begin
                cur_byte   = cfg_byte(cfg_idx);
                if (cur_byte == CLEAR)
                    wait_ld = ld(T_CLEAR);
                if (cfg_idx == 2'd3)
                    next_state = IDLE;
            end
            SET_ADDR: begin
                cur_byte   = SET_DDRAM | {1'b0, POS};
                next_state = WR_CHAR;
            end
            WR_CHAR: begin
                cur_byte   = shadow;
                cur_rs     = 1'b1;
                next_state = IDLE;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= PWR_WAIT;
            step       <= S_START;
            lo         <= 1'b0;
            cnt        <= '0;
            cfg_idx    <= 2'd0;
            shadow     <= 8'h00;
            last       <= 8'h00;
            valid_last <= 1'b0;
            ready      <= 1'b0;
            nib_start  <= 1'b0;
            nib_val    <= 4'h0;
            nib_rs     <= 1'b0;
        end else begin
            nib_start <= 1'b0;
            if (state == IDLE) begin
                if (!valid_last || data != last) begin
                    shadow <= data;
                    ready  <= 1'b0;
                    state  <= SET_ADDR;
                    step   <= S_START;
                    lo     <= 1'b0;
                end
            end else begin
                unique case (step)
                    S_START: begin
                        if (state == PWR_WAIT) begin
                            cnt  <= wait_ld;
                            step <= S_DELAY;
                        end else begin
                            nib_start <= 1'b1;
                            nib_rs    <= cur_rs;
                            step      <= S_WAIT_NIB;
                            if (nib_only)
                                nib_val <= nib_code;
                            else if (lo)
                                nib_val <= cur_byte[3:0];
                            else
                                nib_val <= cur_byte[7:4];
                        end
                    end
                    S_WAIT_NIB: begin
                        if (nib_done) begin
                            if (!nib_only && !lo) begin
                                lo   <= 1'b1;
                                cnt  <= ld(T_NIBGAP);
                                step <= S_GAP;
                            end else begin
                                cnt  <= wait_ld;
                                step <= S_DELAY;
                            end
                        end
                    end
                    S_GAP: begin
                        if (cnt == '0)
                            step <= S_START;
                        else
                            cnt <= cnt - 1'b1;
                    end
                    S_DELAY: begin
                        if (cnt == '0) begin
                            step  <= S_START;
                            lo    <= 1'b0;
                            state <= next_state;
                            if (state == CFG)
                                cfg_idx <= cfg_idx + 2'd1;
                            if (state == WR_CHAR) begin
                                last       <= shadow;
                                valid_last <= 1'b1;
                            end
                            if (next_state == IDLE)
                                ready <= 1'b1;
                        end else begin
                            cnt <= cnt - 1'b1;
                        end
                    end
                    default: step <= S_START;
                endcase
            end
        end
    end

endmodule
